interrupt_controller: RTL and testbench

//   Collects external interrupt lines and requests service from the CPU control unit.

---
 rtl/interrupt_controller_pkg.sv | 18 +
 rtl/interrupt_controller_priority_encoder.sv | 24 ++
 rtl/interrupt_controller.sv | 171 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants, FSM state type and vector helper for the interrupt controller.
// The I/O addresses sit in the low I/O window, clear of SREG (0x3F) and SPL (0x3D).
package interrupt_controller_pkg;

    localparam logic [15:0] IC_ADDR_IFR  = 16'h003A;
    localparam logic [15:0] IC_ADDR_IMSK = 16'h003B;

    typedef enum logic [0:0] {
        IC_STATE_IDLE    = 1'b0,
        IC_STATE_REQUEST = 1'b1
    } ic_state_e;

    // Entry 0 of the table is the reset vector, so source idx maps to entry idx+1.
    function automatic logic [31:0] ic_vector_calc(input logic [31:0] idx, input logic [31:0] stride);
        return (idx + 32'd1) * stride;
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Lowest-set-bit priority encoder: index 0 has the highest priority.
module priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = {IDX_W{1'b0}};
        valid_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller with IMSK/IFR I/O registers and a request/ack FSM.
// Optional IRQ_SYNC_EN adds a two-flop synchronizer on every irq_lines bit.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int I_ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int IRQ_LINES     = 8,
    parameter int VECTOR_STRIDE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IRQ_LINES-1:0]    irq_lines,
    input  logic                    global_ie,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    input  logic                    ack,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    inout  wire  [DATA_WIDTH-1:0]   bus_data,
    input  logic                    io_cs,
    input  logic                    io_we,
    input  logic                    io_oe
);

    localparam int IDX_W = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1;
    localparam logic [ADDR_WIDTH-1:0] IMSK_A = ADDR_WIDTH'(IC_ADDR_IMSK);
    localparam logic [ADDR_WIDTH-1:0] IFR_A  = ADDR_WIDTH'(IC_ADDR_IFR);

    logic [IRQ_LINES-1:0]    lines_s, edge_s, active_s, wdata_s, clr_s, ack_mask_s;
    logic [IRQ_LINES-1:0]    prev_q, pending_q, pending_d, mask_q, mask_d;
    ic_state_e               state_q, state_d;
    logic                    irq_q, irq_d;
    logic [I_ADDR_WIDTH-1:0] vector_q, vector_d, enc_vec_s;
    logic [IDX_W-1:0]        idx_q, idx_d, enc_idx_s;
    logic                    enc_valid_s, ack_clr_s;
    logic                    sel_imsk_s, sel_ifr_s, wr_s, rd_s;
    logic [DATA_WIDTH-1:0]   rdata_s;

`ifdef IRQ_SYNC_EN
    logic [IRQ_LINES-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer so irq_lines may come from another clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= {IRQ_LINES{1'b0}};
            sync2_q <= {IRQ_LINES{1'b0}};
        end else begin
            sync1_q <= irq_lines;
            sync2_q <= sync1_q;
        end
    end

    assign lines_s = sync2_q;
`else
    assign lines_s = irq_lines;
`endif

    assign edge_s   = lines_s & ~prev_q;
    assign active_s = pending_q & mask_q;

    priority_encoder #(
        .N     (IRQ_LINES),
        .IDX_W (IDX_W)
    ) u_prio (
        .req_i   (active_s),
        .idx_o   (enc_idx_s),
        .valid_o (enc_valid_s)
    );

    assign enc_vec_s = I_ADDR_WIDTH'(ic_vector_calc(32'(enc_idx_s), 32'(VECTOR_STRIDE)));

    assign sel_imsk_s = (bus_addr == IMSK_A);
    assign sel_ifr_s  = (bus_addr == IFR_A);
    assign wr_s       = io_cs && io_we;
    assign rd_s       = io_cs && io_oe && (sel_imsk_s || sel_ifr_s);
    assign wdata_s    = bus_data[IRQ_LINES-1:0];

    // Read mux; bits at and above IRQ_LINES always read as zero.
    always_comb begin
        rdata_s = {DATA_WIDTH{1'b0}};
        if (sel_imsk_s) begin
            rdata_s[IRQ_LINES-1:0] = mask_q;
        end else if (sel_ifr_s) begin
            rdata_s[IRQ_LINES-1:0] = pending_q;
        end else begin
            rdata_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign bus_data = rd_s ? rdata_s : {DATA_WIDTH{1'bz}};

    // Mask/pending next state: clears are applied first so a same-cycle edge wins.
    always_comb begin
        mask_d     = mask_q;
        clr_s      = {IRQ_LINES{1'b0}};
        ack_mask_s = ack_clr_s ? (IRQ_LINES'(1'b1) << idx_q) : {IRQ_LINES{1'b0}};
        if (wr_s && sel_imsk_s) begin
            mask_d = wdata_s;
        end else begin
            mask_d = mask_q;
        end
        if (wr_s && sel_ifr_s) begin
            clr_s = wdata_s | ack_mask_s;
        end else begin
            clr_s = ack_mask_s;
        end
        pending_d = (pending_q & ~clr_s) | edge_s;
    end

    // Request FSM: once in REQUEST only ack can release irq and vector.
    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        vector_d  = vector_q;
        idx_d     = idx_q;
        ack_clr_s = 1'b0;
        case (state_q)
            IC_STATE_IDLE: begin
                if (global_ie && enc_valid_s) begin
                    state_d  = IC_STATE_REQUEST;
                    irq_d    = 1'b1;
                    vector_d = enc_vec_s;
                    idx_d    = enc_idx_s;
                end else begin
                    state_d = IC_STATE_IDLE;
                    irq_d   = 1'b0;
                end
            end
            IC_STATE_REQUEST: begin
                if (ack) begin
                    state_d   = IC_STATE_IDLE;
                    irq_d     = 1'b0;
                    ack_clr_s = 1'b1;
                end else begin
                    state_d = IC_STATE_REQUEST;
                    irq_d   = 1'b1;
                end
            end
            default: begin
                state_d = IC_STATE_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    // State and register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IC_STATE_IDLE;
            irq_q     <= 1'b0;
            vector_q  <= {I_ADDR_WIDTH{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            pending_q <= {IRQ_LINES{1'b0}};
            mask_q    <= {IRQ_LINES{1'b0}};
            prev_q    <= {IRQ_LINES{1'b0}};
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            vector_q  <= vector_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            prev_q    <= lines_s;
        end
    end

    assign irq    = irq_q;
    assign vector = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the interrupt rules.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    localparam int STRIDE = 1;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_lines;
    logic        global_ie, ack, io_cs, io_we, io_oe;
    logic [15:0] bus_addr;
    logic        tb_drv;
    logic [7:0]  tb_wdata;
    wire  [7:0]  bus_data;
    wire         irq;
    wire  [9:0]  vector;

    int compared = 0;
    int mismatched = 0;

    // behavioural model state
    logic [7:0] m_pend, m_mask, m_prev, m_h1, m_h2;
    bit         m_irq;
    int         m_idx, m_vec;

    assign bus_data = tb_drv ? tb_wdata : 8'hzz;

    interrupt_controller #(
        .I_ADDR_WIDTH(10), .DATA_WIDTH(8), .ADDR_WIDTH(16), .IRQ_LINES(8), .VECTOR_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .reset(reset), .irq_lines(irq_lines), .global_ie(global_ie),
        .irq(irq), .vector(vector), .ack(ack), .bus_addr(bus_addr), .bus_data(bus_data),
        .io_cs(io_cs), .io_we(io_we), .io_oe(io_oe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00; m_h1 = 8'h00; m_h2 = 8'h00;
        m_irq = 1'b0; m_idx = 0; m_vec = 0;
    endtask

    // One clock edge of the interrupt rules, using the inputs present at that edge.
    task automatic model_step();
        logic [7:0] seen, clr, edges, new_mask;
        int sel;
        if (reset) begin
            model_reset();
            return;
        end
        seen     = (SYNC_LAT != 0) ? m_h2 : irq_lines;
        edges    = seen & ~m_prev;
        clr      = 8'h00;
        new_mask = m_mask;
        if (io_cs && io_we && bus_addr == IC_ADDR_IFR)  clr = tb_wdata;
        if (io_cs && io_we && bus_addr == IC_ADDR_IMSK) new_mask = tb_wdata;
        if (m_irq) begin
            if (ack) begin
                clr[m_idx] = 1'b1;
                m_irq = 1'b0;
            end
        end else if (global_ie) begin
            sel = -1;
            for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) sel = i;
            if (sel >= 0) begin
                m_irq = 1'b1;
                m_idx = sel;
                m_vec = ((sel + 1) * STRIDE) % 1024;
            end
        end
        m_pend = (m_pend & ~clr) | edges;
        m_mask = new_mask;
        m_prev = seen;
        m_h2   = m_h1;
        m_h1   = irq_lines;
    endtask

    task automatic idle_bus();
        io_cs = 1'b0; io_we = 1'b0; io_oe = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
        if (m_irq) check_eq("vector", {22'd0, vector}, m_vec);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        io_cs = 1'b1; io_we = 1'b1; io_oe = 1'b0; bus_addr = addr; tb_drv = 1'b1; tb_wdata = data;
        step();
        idle_bus();
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        io_cs = 1'b1; io_oe = 1'b1; io_we = 1'b0; tb_drv = 1'b0; bus_addr = addr;
        #1;
        data = bus_data;
        idle_bus();
    endtask

    logic [7:0] rd;
    logic [15:0] ra;
    int r;

    initial begin
        reset = 1'b1; irq_lines = 8'h00; global_ie = 1'b0; ack = 1'b0;
        bus_addr = 16'h0000; tb_wdata = 8'h00;
        idle_bus();
        model_reset();
        @(negedge clk);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_vector", {22'd0, vector}, 32'd0);
        bus_read(IC_ADDR_IMSK, rd); check_eq("rst_imsk", {24'd0, rd}, 32'h00);
        bus_read(IC_ADDR_IFR, rd);  check_eq("rst_ifr", {24'd0, rd}, 32'h00);
        step();
        reset = 1'b0;
        step();

        // basic request/ack on line 2
        bus_write(IC_ADDR_IMSK, 8'h05);
        global_ie = 1'b1;
        irq_lines = 8'h04; step(); irq_lines = 8'h00;
        repeat (SYNC_LAT) step();
        bus_read(IC_ADDR_IFR, rd); check_eq("s1_ifr", {24'd0, rd}, 32'h04);
        check_eq("s1_irq_low", {31'd0, irq}, 32'd0);
        step();
        check_eq("s1_irq_high", {31'd0, irq}, 32'd1);
        check_eq("s1_vector", {22'd0, vector}, 32'd3);
        ack = 1'b1; global_ie = 1'b0; step(); ack = 1'b0;
        check_eq("s1_irq_ack", {31'd0, irq}, 32'd0);
        bus_read(IC_ADDR_IFR, rd); check_eq("s1_ifr_clr", {24'd0, rd}, 32'h00);

        // global_ie gating on line 0
        irq_lines = 8'h01; step(); irq_lines = 8'h00;
        repeat (SYNC_LAT + 2) step();
        check_eq("s3_gated", {31'd0, irq}, 32'd0);
        global_ie = 1'b1; step();
        check_eq("s3_irq", {31'd0, irq}, 32'd1);
        check_eq("s3_vector", {22'd0, vector}, 32'd1);
        ack = 1'b1; global_ie = 1'b0; step(); ack = 1'b0;

        // simultaneous edges, frozen request, priority order
        bus_write(IC_ADDR_IMSK, 8'hFF);
        irq_lines = 8'h22; step(); irq_lines = 8'h00;
        repeat (SYNC_LAT + 1) step();
        global_ie = 1'b1; step();
        check_eq("s2_first", {22'd0, vector}, 32'd2);
        global_ie = 1'b0;
        bus_write(IC_ADDR_IMSK, 8'h00);
        step();
        check_eq("s4_frozen_irq", {31'd0, irq}, 32'd1);
        check_eq("s4_frozen_vec", {22'd0, vector}, 32'd2);
        ack = 1'b1; step(); ack = 1'b0;
        bus_write(IC_ADDR_IMSK, 8'hFF);
        global_ie = 1'b1; step();
        check_eq("s2_second", {22'd0, vector}, 32'd6);
        ack = 1'b1; global_ie = 1'b0; step(); ack = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;
        check_eq("s4_ack_idle", {31'd0, irq}, 32'd0);
        bus_read(IC_ADDR_IFR, rd); check_eq("s4_ifr", {24'd0, rd}, 32'h00);

        // IFR write-1-to-clear, and edge coinciding with ack
        irq_lines = 8'h80; step(); irq_lines = 8'h00;
        repeat (SYNC_LAT) step();
        bus_read(IC_ADDR_IFR, rd); check_eq("s5_ifr_set", {24'd0, rd}, 32'h80);
        bus_write(IC_ADDR_IFR, 8'hFF);
        bus_read(IC_ADDR_IFR, rd); check_eq("s5_ifr_w1c", {24'd0, rd}, 32'h00);
        global_ie = 1'b1;
        irq_lines = 8'h08; step(); irq_lines = 8'h00;
        repeat (SYNC_LAT + 1) step();
        check_eq("s5_vector", {22'd0, vector}, 32'd4);
        irq_lines = 8'h08;
        repeat (SYNC_LAT) step();
        ack = 1'b1; global_ie = 1'b0; step(); ack = 1'b0;
        bus_read(IC_ADDR_IFR, rd); check_eq("s5_set_wins", {24'd0, rd}, 32'h08);
        irq_lines = 8'h00;
        bus_write(IC_ADDR_IFR, 8'h08);
        repeat (SYNC_LAT + 1) step();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 15);
            if (r == 2 || r == 3) begin
                ra = (r == 2) ? IC_ADDR_IMSK : IC_ADDR_IFR;
                bus_read(ra, rd);
                check_eq((r == 2) ? "rnd_imsk" : "rnd_ifr", {24'd0, rd},
                         {24'd0, (r == 2) ? m_mask : m_pend});
            end
            if ($urandom_range(0, 7) == 0) irq_lines[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) global_ie = ~global_ie;
            ack = m_irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            idle_bus();
            if (r == 0 || r == 1 || r == 4) begin
                io_cs = 1'b1; io_we = 1'b1; tb_drv = 1'b1; tb_wdata = 8'($urandom);
                bus_addr = (r == 0) ? IC_ADDR_IMSK : ((r == 1) ? IC_ADDR_IFR : 16'h003F);
            end
            step();
            idle_bus();
            ack = 1'b0;
        end

        // reset in the middle of a request
        irq_lines = 8'h00; global_ie = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;
        bus_write(IC_ADDR_IFR, 8'hFF);
        bus_write(IC_ADDR_IMSK, 8'hFF);
        irq_lines = 8'h10; step(); irq_lines = 8'h00;
        global_ie = 1'b1;
        repeat (SYNC_LAT + 1) step();
        check_eq("s6_pre_irq", {31'd0, irq}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("s6_irq", {31'd0, irq}, 32'd0);
        check_eq("s6_vector", {22'd0, vector}, 32'd0);
        bus_read(IC_ADDR_IMSK, rd); check_eq("s6_imsk", {24'd0, rd}, 32'h00);
        bus_read(IC_ADDR_IFR, rd);  check_eq("s6_ifr", {24'd0, rd}, 32'h00);
        model_reset();
        step();
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
